// File: rtl/aes_round_sched.sv
// Round sequencer for an iterative AES core: feeds one block through NR passes of a
// shared round datapath, with a per-round response timeout.
module aes_round_sched #(
    parameter int DATA_W  = 128,
    parameter int NR      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              dp_valid_out,
    output logic [DATA_W-1:0] dp_data_out,
    output logic [3:0]        dp_round,
    output logic              dp_final,
    input  logic              dp_valid_in,
    input  logic [DATA_W-1:0] dp_data_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LP_NR      = 4'(NR);
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_data_out;
    logic [3:0]        r_round;
    logic [7:0]        r_tcnt;
    logic              r_valid_out;
    logic              r_err;

    logic w_last_round;
    logic w_expire;

    assign w_last_round = (r_round == LP_NR);
    assign w_expire     = (r_tcnt == LP_TO_LAST);

    // A response in the final silent WAIT cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_data_out  <= '0;
            r_round     <= 4'd0;
            r_tcnt      <= 8'd0;
            r_valid_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data  <= data_in;
                        r_round <= 4'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tcnt  <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (dp_valid_in) begin
                        r_data <= dp_data_in;
                        if (w_last_round) begin
                            r_state <= S_DONE;
                        end else begin
                            r_round <= r_round + 4'd1;
                            r_state <= S_ISSUE;
                        end
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_round <= 4'd0;
                        r_tcnt  <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_valid_out <= 1'b1;
                    r_data_out  <= r_data;
                    r_round     <= 4'd0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign dp_valid_out = (r_state == S_ISSUE);
    assign dp_data_out  = r_data;
    assign dp_round     = r_round;
    assign dp_final     = w_last_round;
    assign valid_out    = r_valid_out;
    assign data_out     = r_data_out;
    assign err          = r_err;

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 Parameter DATA_W, default 128, state width in bits.
REQ-002 Parameter NR, default 10, number of rounds issued per block (AES-128); legal range 2..15.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles per round before abort; legal range 1..255.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to process one block; sampled only in IDLE.
REQ-007 data_in  input  DATA_W  whitened input state (round-0 AddRoundKey already applied); captured with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 dp_valid_out  output  1  one-cycle issue strobe to the shared round datapath.
REQ-010 dp_data_out  output  DATA_W  state presented to the datapath; equals internal state register.
REQ-011 dp_round  output  4  round index 1..NR of the current issue; 0 in IDLE.
REQ-012 dp_final  output  1  high when dp_round == NR; datapath bypasses MixColumns.
REQ-013 dp_valid_in  input  1  datapath result strobe.
REQ-014 dp_data_in  input  DATA_W  datapath result, valid with dp_valid_in.
REQ-015 valid_out  output  1  one-cycle result strobe.
REQ-016 data_out  output  DATA_W  ciphertext; holds last result until next valid_out.
REQ-017 err  output  1  one-cycle pulse on round timeout.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered or decoded from registered state only.
REQ-019 IDLE: start=1 -> capture data_in into state register, round <= 1, go ISSUE; start=0 -> stay.
REQ-020 ISSUE: dp_valid_out=1 for exactly this one cycle; clear timeout counter; next state WAIT unconditionally.
REQ-021 WAIT: dp_valid_in=1 -> state <= dp_data_in; if round == NR go DONE, else round <= round+1 and go ISSUE.
REQ-022 WAIT: timeout counter increments each cycle without dp_valid_in; reaching TIMEOUT -> err pulse, round <= 0, go IDLE; state register and data_out unchanged.
REQ-023 dp_valid_in and timeout expiry in same cycle -> response wins, no err.
REQ-024 dp_valid_in outside WAIT ignored; state register unchanged.
REQ-025 start while busy=1 (including DONE) ignored, not queued.
REQ-026 DONE: valid_out=1 and data_out <= state register for this one cycle; next state IDLE; start accepted earliest on the following IDLE cycle.
REQ-027 Latency with datapath response L cycles after dp_valid_out (L>=1, L<=TIMEOUT): valid_out asserted 1+NR*(1+L) cycles after start sampled; NR=10, L=1 -> 21 cycles.
REQ-028 Round counter 4 bits; never exceeds NR; no wrap.
REQ-029 dp_final high only while dp_round == NR; 0 in IDLE.

Reset
REQ-030 reset low asynchronously forces IDLE; busy, dp_valid_out, valid_out, err, dp_final = 0; dp_round = 0; state register and data_out = 0; timeout counter = 0.
REQ-031 reset asserted mid-block abandons the block with no valid_out or err; a datapath response arriving after reset release is ignored per REQ-024.

Verification
REQ-032 FIPS-197 C.1 vector, round datapath model L=1: start with whitened state -> exactly 10 dp_valid_out pulses, dp_round 1..10, dp_final only on 10th, valid_out at cycle 21 with data_out = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Model L=3: valid_out at cycle 41; start pulses every cycle while busy -> no extra issues, single result.
REQ-034 Datapath silent in round 4, TIMEOUT=15 -> err pulse 15 cycles after the 4th ISSUE, busy low next cycle, no valid_out, data_out unchanged.
REQ-035 Response on exact timeout-expiry cycle -> no err, sequencing continues to round 5.
REQ-036 reset low during WAIT of round 6 -> all outputs 0 immediately; new start after release -> correct ciphertext with full 10 rounds.
REQ-037 Back-to-back: start held high continuously -> second block begins one cycle after DONE, results in order, spacing 22 cycles at L=1.
